// File: rtl/ex_muldiv_if.sv
// Handshake and writeback bundle between the EX stage / ctrl / regs and the
// multi-cycle RV32M unit. The master side is the pipeline, the slave side is
// the multiply/divide engine.
interface ex_muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            busy_o;
    logic            hold_flag_o;
    logic [4:0]      rd_addr_o;
    logic [XLEN-1:0] rd_data_o;
    logic            rd_wen_o;

    modport master (
        output start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
        input  busy_o, hold_flag_o, rd_addr_o, rd_data_o, rd_wen_o
    );

    modport slave (
        input  start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
        output busy_o, hold_flag_o, rd_addr_o, rd_data_o, rd_wen_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit. Multiplies with a shift-add engine and
// divides with a restoring engine, both working on operand magnitudes, one
// bit per cycle. Divide-by-zero, signed overflow and (optionally) all
// multiplies bypass the iterative engine and finish the cycle after start.
module ex_muldiv #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input logic        clk,
    input logic        rst_n,
    ex_muldiv_if.slave bus
);

    localparam int              CW       = (XLEN > 2) ? $clog2(XLEN) : 2;
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] XONES    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] XZERO    = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Apply the product sign and pick the half the op asks for.
    function automatic logic [XLEN-1:0] mul_select(input logic [1:0] sel,
                                                   input logic [2*XLEN-1:0] mag,
                                                   input logic neg);
        logic [2*XLEN-1:0] prod;
        if (neg) begin
            prod = {(2*XLEN){1'b0}} - mag;
        end else begin
            prod = mag;
        end
        if (sel == 2'b00) begin
            return prod[XLEN-1:0];
        end else begin
            return prod[2*XLEN-1:XLEN];
        end
    endfunction

    // Pick quotient or remainder from {rem, quo} and apply its sign.
    function automatic logic [XLEN-1:0] div_select(input logic is_rem,
                                                   input logic [2*XLEN-1:0] acc,
                                                   input logic neg);
        logic [XLEN-1:0] val;
        if (is_rem) begin
            val = acc[2*XLEN-1:XLEN];
        end else begin
            val = acc[XLEN-1:0];
        end
        if (neg) begin
            return XZERO - val;
        end else begin
            return val;
        end
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [2:0]        op_r;
    logic [4:0]        rd_r;
    logic              neg_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   b_r;
    logic [CW-1:0]     cnt_r;

    logic              rd_wen_r;
    logic [4:0]        rd_addr_r;
    logic [XLEN-1:0]   rd_data_r;

    logic              signed_a_s;
    logic              signed_b_s;
    logic              sign_a_s;
    logic              sign_b_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic              neg_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic              special_s;
    logic [2*XLEN-1:0] fast_prod_s;
    logic [XLEN-1:0]   special_data_s;

    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] acc_mul_s;
    logic [XLEN:0]     div_trial_s;
    logic [XLEN:0]     div_diff_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] acc_div_s;
    logic [2*XLEN-1:0] acc_step_s;
    logic [XLEN-1:0]   final_s;

    logic              hold_s;
    logic              load_s;
    logic              step_s;
    logic              out_load_s;
    logic [4:0]        out_rd_s;
    logic [XLEN-1:0]   out_data_s;

    // Decode the incoming op: operand signedness, magnitudes, result sign and short-cut results.
    always_comb begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
        case (bus.op_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b1;
            end
            3'b010: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b0;
            end
            default: begin
                signed_a_s = 1'b0;
                signed_b_s = 1'b0;
            end
        endcase
        sign_a_s = signed_a_s & bus.rs1_data_i[XLEN-1];
        sign_b_s = signed_b_s & bus.rs2_data_i[XLEN-1];
        mag_a_s  = sign_a_s ? (XZERO - bus.rs1_data_i) : bus.rs1_data_i;
        mag_b_s  = sign_b_s ? (XZERO - bus.rs2_data_i) : bus.rs2_data_i;
        // A remainder takes the dividend's sign; everything else takes sA^sB.
        neg_s      = (bus.op_i[2] & bus.op_i[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
        div_zero_s = bus.op_i[2] & (bus.rs2_data_i == XZERO);
        div_ovf_s  = bus.op_i[2] & ~bus.op_i[0] & (bus.rs1_data_i == XMIN)
                     & (bus.rs2_data_i == XONES);
        fast_prod_s = {{XLEN{1'b0}}, mag_a_s} * {{XLEN{1'b0}}, mag_b_s};
        special_s   = div_zero_s | div_ovf_s | (FAST_MUL & ~bus.op_i[2]);
        if (div_zero_s) begin
            special_data_s = bus.op_i[1] ? bus.rs1_data_i : XONES;
        end else if (div_ovf_s) begin
            special_data_s = bus.op_i[1] ? XZERO : XMIN;
        end else begin
            special_data_s = mul_select(bus.op_i[1:0], fast_prod_s, neg_s);
        end
    end

    // One iteration of the shift-add multiply or restoring divide, plus the signed final result.
    always_comb begin
        // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]}
                    + (acc_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
        acc_mul_s = {mul_sum_s, acc_r[XLEN-1:1]};
        // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
        div_trial_s = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s  = div_trial_s - {1'b0, b_r};
        div_ge_s    = ~div_diff_s[XLEN];
        acc_div_s   = {(div_ge_s ? div_diff_s[XLEN-1:0] : div_trial_s[XLEN-1:0]),
                       acc_r[XLEN-2:0], div_ge_s};
        acc_step_s  = op_r[2] ? acc_div_s : acc_mul_s;
        if (op_r[2]) begin
            final_s = div_select(op_r[1], acc_step_s, neg_r);
        end else begin
            final_s = mul_select(op_r[1:0], acc_step_s, neg_r);
        end
    end

    // Next-state, stall and writeback-load decisions.
    always_comb begin
        state_next_s = state_r;
        hold_s       = 1'b0;
        load_s       = 1'b0;
        step_s       = 1'b0;
        out_load_s   = 1'b0;
        out_rd_s     = rd_r;
        out_data_s   = final_s;
        case (state_r)
            ST_IDLE: begin
                out_rd_s   = bus.rd_addr_i;
                out_data_s = special_data_s;
                if (bus.start_i & ~bus.flush_i) begin
                    hold_s = 1'b1;
                    if (special_s) begin
                        state_next_s = ST_DONE;
                        out_load_s   = 1'b1;
                    end else begin
                        state_next_s = ST_CALC;
                        load_s       = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                hold_s = 1'b1;
                if (bus.flush_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    step_s = 1'b1;
                    if (cnt_r == CNT_ZERO) begin
                        state_next_s = ST_DONE;
                        out_load_s   = 1'b1;
                    end else begin
                        state_next_s = ST_CALC;
                    end
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r  <= 3'b000;
            rd_r  <= 5'd0;
            neg_r <= 1'b0;
            acc_r <= {(2*XLEN){1'b0}};
            b_r   <= XZERO;
            cnt_r <= CNT_ZERO;
        end else if (load_s) begin
            op_r  <= bus.op_i;
            rd_r  <= bus.rd_addr_i;
            neg_r <= neg_s;
            // Divide iterates on |A| against |B|; multiply shifts |B| out against |A|.
            acc_r <= bus.op_i[2] ? {XZERO, mag_a_s} : {XZERO, mag_b_s};
            b_r   <= bus.op_i[2] ? mag_b_s : mag_a_s;
            cnt_r <= CNT_INIT;
        end else if (step_s) begin
            acc_r <= acc_step_s;
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Writeback registers: populated only for the single DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_wen_r  <= 1'b0;
            rd_addr_r <= 5'd0;
            rd_data_r <= XZERO;
        end else if (out_load_s) begin
            rd_wen_r  <= (out_rd_s != 5'd0);
            rd_addr_r <= out_rd_s;
            rd_data_r <= out_data_s;
        end else begin
            rd_wen_r  <= 1'b0;
            rd_addr_r <= 5'd0;
            rd_data_r <= XZERO;
        end
    end

    assign bus.busy_o      = (state_r != ST_IDLE);
    assign bus.hold_flag_o = hold_s;
    assign bus.rd_wen_o    = rd_wen_r;
    assign bus.rd_addr_o   = rd_addr_r;
    assign bus.rd_data_o   = rd_data_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: one iterative instance and one FAST_MUL
// instance, driven from a single linear sequence of steps.
module tb_ex_muldiv;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    ex_muldiv_if #(.XLEN(32)) bs ();
    ex_muldiv_if #(.XLEN(32)) bf ();

    ex_muldiv #(.XLEN(32), .FAST_MUL(1'b0)) u_slow (.clk(clk), .rst_n(rst_n), .bus(bs));
    ex_muldiv #(.XLEN(32), .FAST_MUL(1'b1)) u_fast (.clk(clk), .rst_n(rst_n), .bus(bf));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_hold(input bit fast);
        return fast ? {31'd0, bf.hold_flag_o} : {31'd0, bs.hold_flag_o};
    endfunction
    function automatic logic [31:0] o_busy(input bit fast);
        return fast ? {31'd0, bf.busy_o} : {31'd0, bs.busy_o};
    endfunction
    function automatic logic [31:0] o_wen(input bit fast);
        return fast ? {31'd0, bf.rd_wen_o} : {31'd0, bs.rd_wen_o};
    endfunction
    function automatic logic [31:0] o_addr(input bit fast);
        return fast ? {27'd0, bf.rd_addr_o} : {27'd0, bs.rd_addr_o};
    endfunction
    function automatic logic [31:0] o_data(input bit fast);
        return fast ? bf.rd_data_o : bs.rd_data_o;
    endfunction

    task automatic drive(input bit fast, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bs.op_i = op;  bf.op_i = op;
        bs.rs1_data_i = a;  bf.rs1_data_i = a;
        bs.rs2_data_i = b;  bf.rs2_data_i = b;
        bs.rd_addr_i = rd;  bf.rd_addr_i = rd;
        if (fast) begin
            bf.start_i = st;  bs.start_i = 1'b0;
        end else begin
            bs.start_i = st;  bf.start_i = 1'b0;
        end
    endtask

    // Start an op in the next cycle (cycle 0) and check stall, latency and writeback.
    task automatic run_op(input bit fast, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int lat, input string tag);
        int bad;
        bad = 0;
        @(posedge clk); #1;
        drive(fast, 1'b1, op, a, b, rd);
        @(negedge clk);
        check({tag, "_hold_c0"}, o_hold(fast), 32'd1);
        for (int c = 1; c < lat; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_hold(fast) !== 32'd1 || o_wen(fast) !== 32'd0 || o_busy(fast) !== 32'd1) bad++;
        end
        if (lat > 1) check({tag, "_calc"}, 32'(bad), 32'd0);
        @(posedge clk); #1;
        drive(fast, 1'b0, op, a, b, rd);
        @(negedge clk);
        check({tag, "_wen"},  o_wen(fast),  (rd != 5'd0) ? 32'd1 : 32'd0);
        check({tag, "_addr"}, o_addr(fast), {27'd0, rd});
        check({tag, "_data"}, o_data(fast), exp);
        check({tag, "_hold_done"}, o_hold(fast), 32'd0);
        check({tag, "_busy_done"}, o_busy(fast), 32'd1);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        bs.flush_i = 1'b0;
        bf.flush_i = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);

        // Reset state
        @(negedge clk);
        check("rst_busy", o_busy(1'b0), 32'd0);
        check("rst_hold", o_hold(1'b0), 32'd0);
        check("rst_wen",  o_wen(1'b0),  32'd0);
        check("rst_addr", o_addr(1'b0), 32'd0);
        check("rst_data", o_data(1'b0), 32'd0);
        check("rst_busy_fast", o_busy(1'b1), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Unsigned divide / remainder, full iterative latency
        run_op(1'b0, 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 33, "divu_100_7");
        run_op(1'b0, 3'b111, 32'd100, 32'd7, 5'd5, 32'd2,  33, "remu_100_7");

        // Signed divide sign rules
        run_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33, "div_m7_2");
        run_op(1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, "rem_m7_2");
        run_op(1'b0, 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'hFFFF_FFFD, 33, "div_7_m2");

        // Short-cut cases finish in cycle 1
        run_op(1'b0, 3'b100, 32'h0000_1234, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, "div_by0");
        run_op(1'b0, 3'b110, 32'h0000_1234, 32'd0, 5'd8, 32'h0000_1234, 1, "rem_by0");
        run_op(1'b0, 3'b101, 32'h0000_1234, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, "divu_by0");
        run_op(1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1, "div_ovf");
        run_op(1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0000_0000, 1, "rem_ovf");
        run_op(1'b0, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0000_0000, 33, "divu_noovf");

        // Iterative multiply
        run_op(1'b0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 33, "mulh_m1");
        run_op(1'b0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0001, 33, "mul_m1");
        run_op(1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, 33, "mulhu_max");
        run_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF, 33, "mulhsu_m1");
        run_op(1'b0, 3'b000, 32'd123456, 32'd789, 5'd11, 32'd97406784, 33, "mul_dec");
        run_op(1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000, 33, "mulh_min");

        // Single-cycle multiply
        run_op(1'b1, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1, "f_mulh_m1");
        run_op(1'b1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0000_0001, 1, "f_mul_m1");
        run_op(1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, 1, "f_mulhu_max");
        run_op(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF, 1, "f_mulhsu_m1");
        run_op(1'b1, 3'b000, 32'd123456, 32'd789, 5'd13, 32'd97406784, 1, "f_mul_dec");
        run_op(1'b1, 3'b101, 32'd100, 32'd7, 5'd13, 32'd14, 33, "f_divu_100_7");

        // rd = 0: DONE happens but no write strobe
        run_op(1'b0, 3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 33, "mul_rd0");
        run_op(1'b1, 3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 1,  "f_mul_rd0");

        // Flush in cycle 10 of a divide
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'b100, 32'd1000, 32'd3, 5'd7);
        repeat (10) @(posedge clk);
        #1;
        bs.flush_i = 1'b1;
        drive(1'b0, 1'b0, 3'b100, 32'd1000, 32'd3, 5'd7);
        @(negedge clk);
        check("flush_busy_c10", o_busy(1'b0), 32'd1);
        @(posedge clk); #1;
        bs.flush_i = 1'b0;
        @(negedge clk);
        check("flush_idle", o_busy(1'b0), 32'd0);
        check("flush_hold", o_hold(1'b0), 32'd0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_wen(1'b0) !== 32'd0 || o_busy(1'b0) !== 32'd0) bad++;
        end
        check("flush_no_wb", 32'(bad), 32'd0);

        // Start together with flush in IDLE is not accepted
        @(posedge clk); #1;
        bs.flush_i = 1'b1;
        drive(1'b0, 1'b1, 3'b101, 32'd50, 32'd5, 5'd4);
        @(negedge clk);
        check("stflush_hold", o_hold(1'b0), 32'd0);
        @(posedge clk); #1;
        bs.flush_i = 1'b0;
        drive(1'b0, 1'b0, 3'b101, 32'd50, 32'd5, 5'd4);
        @(negedge clk);
        check("stflush_busy", o_busy(1'b0), 32'd0);

        // Reset in cycle 5 of a divide
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'b100, 32'd1000, 32'd3, 5'd9);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'b100, 32'd1000, 32'd3, 5'd9);
        @(negedge clk);
        check("rst5_busy", o_busy(1'b0), 32'd0);
        check("rst5_hold", o_hold(1'b0), 32'd0);
        check("rst5_wen",  o_wen(1'b0),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset during the DONE cycle clears the writeback at once
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'b100, 32'h0000_0055, 32'd0, 5'd3);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b100, 32'h0000_0055, 32'd0, 5'd3);
        check("rstdone_pre_wen", o_wen(1'b0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstdone_wen",  o_wen(1'b0),  32'd0);
        check("rstdone_addr", o_addr(1'b0), 32'd0);
        check("rstdone_data", o_data(1'b0), 32'd0);
        check("rstdone_busy", o_busy(1'b0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Normal operation after reset
        run_op(1'b0, 3'b101, 32'd9, 32'd3, 5'd1, 32'd3, 33, "post_rst_divu");
        @(negedge clk);
        check("final_idle", o_busy(1'b0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
